hv_mem_port_arbiter: RTL and testbench
======================================

// Module: hv_mem_port_arbiter
//
// PURPOSE
// Memory-side responder for the kernel mapper's per-kernel RAM request ports.
// Up to NUM_PORTS kernels issue read and write requests. The block picks up to
// NUM_BANK_PORTS of them per cycle, round-robin, and drives the physical
// multi-port hypervector RAM. Read data is routed back to the requesting kernel
// with a fixed latency. It sits between the parallel bundle/bind kernels and the
// RAM, replacing the ideal one-RAM-port-per-kernel model.
//
// PARAMETERS
// HV_DATA_WIDTH     32  width of one hypervector word
// HV_ADDRESS_WIDTH  5   RAM word-address width
// NUM_PORTS         4   kernel-side request ports (>=1)
// NUM_BANK_PORTS    2   physical RAM ports (1..NUM_PORTS)
// RD_LATENCY        1   RAM clocks from command to mem_data_rd valid (>=1)
//
// PORTS
// clk          in   1                  clock, all logic on rising edge
// reset        in   1                  synchronous, active-high reset
// req          in   NUM_PORTS          per-port request, held until gnt
// we_n         in   NUM_PORTS          per-port 0=write, 1=read
// address      in   NUM_PORTS x AW     per-port word address
// data_wr      in   NUM_PORTS x DW     per-port write data
// gnt          out  NUM_PORTS          request accepted this cycle (comb.)
// data_rd      out  NUM_PORTS x DW     read data returned to port
// rd_valid     out  NUM_PORTS          1-cycle pulse, data_rd valid
// mem_we_n     out  NUM_BANK_PORTS     RAM write enable, active-low
// mem_address  out  NUM_BANK_PORTS x AW  RAM address
// mem_data_wr  out  NUM_BANK_PORTS x DW  RAM write data
// mem_data_rd  in   NUM_BANK_PORTS x DW  RAM read data
//
// BEHAVIOUR
// - Reset (sync): gnt=0, rd_valid=0, data_rd=0, mem_we_n='1, mem_address=0,
//   mem_data_wr=0, rr_ptr=0, all in-flight read tags cleared.
// - Handshake: a port raises req with we_n/address/data_wr stable and holds them
//   until the cycle gnt=1. A grant consumes the request. A port may re-request
//   in the next cycle.
// - Arbitration, cycle N: scan ports rr_ptr, rr_ptr+1, ... mod NUM_PORTS. Grant
//   the first NUM_BANK_PORTS eligible requesters. Slot k is the k-th granted.
// - Address conflict: skip a candidate whose address equals an already-selected
//   address this cycle if either one is a write. Read-read to the same address
//   is allowed. A skipped port keeps req and retries next cycle.
// - rr_ptr <= (last granted port + 1) mod NUM_PORTS when any grant is given,
//   else unchanged. Guarantees no starvation.
// - Cycle N+1: mem_* for slot k is registered from the granted port. Unused
//   slots drive mem_we_n=1, address=0, data=0.
// - Tag pipeline: depth RD_LATENCY per slot, holding {valid, is_read, port}.
// - Read return: at cycle N+1+RD_LATENCY, data_rd[port] <= mem_data_rd[k] and
//   rd_valid[port] pulses for 1 cycle. Total read latency, gnt to rd_valid, is
//   1+RD_LATENCY cycles.
// - data_rd[port] holds its last value otherwise.
// - Writes produce no response. A read granted in a later cycle than a write to
//   the same address returns the new data.
// - Fully pipelined: a new grant set is possible every cycle. Back-to-back reads
//   from the same port return in order.
// - Reset mid-operation: all in-flight tags are dropped. No rd_valid is emitted
//   for requests granted before reset. Pending writes already on mem_* complete.
//
// TESTING
// 1. Reset held 2 cycles with req='1 -> gnt=0, rd_valid=0, mem_we_n=2'b11
//    throughout.
// 2. Port0 writes 32'hDEADBEEF @addr 3 (gnt N). Then reads addr 3 (gnt N+1) ->
//    rd_valid[0] at N+3, data_rd[0]=32'hDEADBEEF.
// 3. Ports 0-3 read addrs 0..3 at once, rr_ptr=0 -> gnt=4'b0011 at N,
//    4'b1100 at N+1. rd_valid follows at N+2 and N+3 with the correct words.
// 4. All ports req continuously for 8 cycles -> each port gets exactly 4 grants.
//    Grant pairs rotate {0,1},{2,3},...
// 5. Port0 write 32'h5 @addr 5 and port1 read addr 5 in the same cycle -> only
//    port0 granted. Port1 granted next cycle, returns 32'h5.
// 6. Reset asserted the cycle after a read grant -> no rd_valid for that read.
//    Arbiter restarts at rr_ptr=0.

Source files
------------

// File: rtl/hv_mem_port_arbiter.sv
// hv_mem_port_arbiter
//
// Connects up to NUM_PORTS kernel request ports to a NUM_BANK_PORTS-port
// hypervector RAM. Each cycle it grants up to NUM_BANK_PORTS requesters in
// round-robin order. It skips any candidate whose address collides with an
// already-selected address when either access is a write. The winners are
// registered onto the RAM ports, and read data is routed back to the
// requesting port.
//
// Read timing: a read granted in cycle N drives mem_* in cycle N+1.
// mem_data_rd for that slot is sampled in cycle N+RD_LATENCY, so with
// RD_LATENCY=1 the RAM read path is combinational from mem_address.
// data_rd/rd_valid appear in cycle N+1+RD_LATENCY.
//
// Ports
//   i_clk          clock, rising edge
//   i_reset        synchronous active-high reset
//   i_req          per-port request, held until granted
//   i_we_n         per-port 0=write, 1=read
//   i_address      per-port word address, packed NUM_PORTS x AW
//   i_data_wr      per-port write data, packed NUM_PORTS x DW
//   o_gnt          per-port grant, combinational, consumes the request
//   o_data_rd      per-port read data, holds its last value
//   o_rd_valid     per-port one-cycle read-return pulse
//   o_mem_we_n     per-bank-port RAM write enable, active low
//   o_mem_address  per-bank-port RAM address
//   o_mem_data_wr  per-bank-port RAM write data
//   i_mem_data_rd  per-bank-port RAM read data
module hv_mem_port_arbiter #(
  parameter int HV_DATA_WIDTH    = 32,
  parameter int HV_ADDRESS_WIDTH = 5,
  parameter int NUM_PORTS        = 4,
  parameter int NUM_BANK_PORTS   = 2,
  parameter int RD_LATENCY       = 1
) (
  input  logic                                     i_clk,
  input  logic                                     i_reset,
  input  logic [NUM_PORTS-1:0]                     i_req,
  input  logic [NUM_PORTS-1:0]                     i_we_n,
  input  logic [NUM_PORTS*HV_ADDRESS_WIDTH-1:0]    i_address,
  input  logic [NUM_PORTS*HV_DATA_WIDTH-1:0]       i_data_wr,
  output logic [NUM_PORTS-1:0]                     o_gnt,
  output logic [NUM_PORTS*HV_DATA_WIDTH-1:0]       o_data_rd,
  output logic [NUM_PORTS-1:0]                     o_rd_valid,
  output logic [NUM_BANK_PORTS-1:0]                o_mem_we_n,
  output logic [NUM_BANK_PORTS*HV_ADDRESS_WIDTH-1:0] o_mem_address,
  output logic [NUM_BANK_PORTS*HV_DATA_WIDTH-1:0]  o_mem_data_wr,
  input  logic [NUM_BANK_PORTS*HV_DATA_WIDTH-1:0]  i_mem_data_rd
);

  localparam int DW = HV_DATA_WIDTH;
  localparam int AW = HV_ADDRESS_WIDTH;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PW-1:0]                r_rr_ptr;
  logic [NUM_PORTS-1:0]         w_gnt;
  logic [NUM_BANK_PORTS-1:0]    w_slot_vld;
  logic [PW-1:0]                w_slot_port [NUM_BANK_PORTS];
  logic [PW-1:0]                w_last_port;
  logic [PW-1:0]                w_cand;
  logic                         w_ok;
  int                           w_cnt;

  logic [NUM_BANK_PORTS-1:0]    r_mem_we_n;
  logic [NUM_BANK_PORTS*AW-1:0] r_mem_address;
  logic [NUM_BANK_PORTS*DW-1:0] r_mem_data_wr;
  logic [NUM_PORTS-1:0]         r_rd_valid;
  logic [NUM_PORTS*DW-1:0]      r_data_rd;

  // Read-return tags, one entry per slot per pipeline stage.
  logic                         r_tag_vld_p  [RD_LATENCY][NUM_BANK_PORTS];
  logic                         r_tag_rd_p   [RD_LATENCY][NUM_BANK_PORTS];
  logic [PW-1:0]                r_tag_port_p [RD_LATENCY][NUM_BANK_PORTS];

  // ---- Stage 0: round-robin selection with address-conflict skipping ----
  always_comb begin
    w_gnt       = '0;
    w_slot_vld  = '0;
    w_last_port = r_rr_ptr;
    w_cand      = '0;
    w_ok        = 1'b0;
    w_cnt       = 0;
    for (int k = 0; k < NUM_BANK_PORTS; k++) w_slot_port[k] = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_cand = PW'((int'(r_rr_ptr) + i) % NUM_PORTS);
      w_ok   = i_req[w_cand] && (w_cnt < NUM_BANK_PORTS);
      // Read-read to one address may share a cycle; anything involving a
      // write must be serialised so the RAM never sees a same-cycle hazard.
      for (int k = 0; k < NUM_BANK_PORTS; k++) begin
        if (w_slot_vld[k] &&
            (i_address[w_slot_port[k]*AW +: AW] == i_address[w_cand*AW +: AW]) &&
            !(i_we_n[w_slot_port[k]] && i_we_n[w_cand]))
          w_ok = 1'b0;
      end
      if (w_ok) begin
        for (int k = 0; k < NUM_BANK_PORTS; k++) begin
          if (k == w_cnt) begin
            w_slot_vld[k]  = 1'b1;
            w_slot_port[k] = w_cand;
          end
        end
        w_gnt[w_cand] = 1'b1;
        w_last_port   = w_cand;
        w_cnt         = w_cnt + 1;
      end
    end
  end

  assign o_gnt = i_reset ? '0 : w_gnt;

  // ---- Stage 1: RAM command registers, tag pipeline, read return ----
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rr_ptr      <= '0;
      r_mem_we_n    <= '1;
      r_mem_address <= '0;
      r_mem_data_wr <= '0;
      r_rd_valid    <= '0;
      r_data_rd     <= '0;
      for (int d = 0; d < RD_LATENCY; d++) begin
        for (int k = 0; k < NUM_BANK_PORTS; k++) begin
          r_tag_vld_p[d][k]  <= 1'b0;
          r_tag_rd_p[d][k]   <= 1'b0;
          r_tag_port_p[d][k] <= '0;
        end
      end
    end else begin
      if (|w_gnt)
        r_rr_ptr <= (int'(w_last_port) == NUM_PORTS - 1) ? '0 : w_last_port + 1'b1;

      for (int k = 0; k < NUM_BANK_PORTS; k++) begin
        if (w_slot_vld[k]) begin
          r_mem_we_n[k]              <= i_we_n[w_slot_port[k]];
          r_mem_address[k*AW +: AW]  <= i_address[w_slot_port[k]*AW +: AW];
          r_mem_data_wr[k*DW +: DW]  <= i_data_wr[w_slot_port[k]*DW +: DW];
        end else begin
          r_mem_we_n[k]              <= 1'b1;
          r_mem_address[k*AW +: AW]  <= '0;
          r_mem_data_wr[k*DW +: DW]  <= '0;
        end
        r_tag_vld_p[0][k]  <= w_slot_vld[k];
        r_tag_rd_p[0][k]   <= i_we_n[w_slot_port[k]];
        r_tag_port_p[0][k] <= w_slot_port[k];
      end

      for (int d = 1; d < RD_LATENCY; d++) begin
        for (int k = 0; k < NUM_BANK_PORTS; k++) begin
          r_tag_vld_p[d][k]  <= r_tag_vld_p[d-1][k];
          r_tag_rd_p[d][k]   <= r_tag_rd_p[d-1][k];
          r_tag_port_p[d][k] <= r_tag_port_p[d-1][k];
        end
      end

      // A port is granted at most once per cycle, so two slots never
      // return to the same port together.
      r_rd_valid <= '0;
      for (int k = 0; k < NUM_BANK_PORTS; k++) begin
        if (r_tag_vld_p[RD_LATENCY-1][k] && r_tag_rd_p[RD_LATENCY-1][k]) begin
          r_rd_valid[r_tag_port_p[RD_LATENCY-1][k]] <= 1'b1;
          r_data_rd[r_tag_port_p[RD_LATENCY-1][k]*DW +: DW] <= i_mem_data_rd[k*DW +: DW];
        end
      end
    end
  end

  assign o_mem_we_n    = r_mem_we_n;
  assign o_mem_address = r_mem_address;
  assign o_mem_data_wr = r_mem_data_wr;
  assign o_rd_valid    = r_rd_valid;
  assign o_data_rd     = r_data_rd;

endmodule

// File: tb/tb_hv_mem_port_arbiter.sv
// Testbench for hv_mem_port_arbiter: 4 kernel ports, 2 RAM ports, RD_LATENCY=1.
// The bench holds a 32-word RAM with a combinational read path and writes on
// the clock edge. It also keeps a reference model of the arbiter built from
// the arbitration and latency rules.
module tb_hv_mem_port_arbiter;
  localparam int NP = 4;
  localparam int NB = 2;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset;
  logic ram_clr;
  logic [NP-1:0]    t_req, t_we_n;
  logic [AW-1:0]    t_addr [NP];
  logic [DW-1:0]    t_wd   [NP];
  logic [NP*AW-1:0] address;
  logic [NP*DW-1:0] data_wr;
  logic [NP-1:0]    gnt, rd_valid;
  logic [NP*DW-1:0] data_rd;
  logic [NB-1:0]    mem_we_n;
  logic [NB*AW-1:0] mem_address;
  logic [NB*DW-1:0] mem_data_wr, mem_data_rd;
  logic [DW-1:0]    ram [32];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    address = '0;
    data_wr = '0;
    for (int p = 0; p < NP; p++) begin
      address[p*AW +: AW] = t_addr[p];
      data_wr[p*DW +: DW] = t_wd[p];
    end
  end

  hv_mem_port_arbiter #(
    .HV_DATA_WIDTH(DW), .HV_ADDRESS_WIDTH(AW), .NUM_PORTS(NP),
    .NUM_BANK_PORTS(NB), .RD_LATENCY(1)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_req(t_req), .i_we_n(t_we_n),
    .i_address(address), .i_data_wr(data_wr), .o_gnt(gnt),
    .o_data_rd(data_rd), .o_rd_valid(rd_valid), .o_mem_we_n(mem_we_n),
    .o_mem_address(mem_address), .o_mem_data_wr(mem_data_wr),
    .i_mem_data_rd(mem_data_rd)
  );

  function automatic logic [DW-1:0] init_word(int i);
    return 32'h1000_0000 + i * 32'h11;
  endfunction

  // RAM environment
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 32; i++) ram[i] <= init_word(i);
    end else begin
      for (int k = 0; k < NB; k++)
        if (mem_we_n[k] === 1'b0) ram[mem_address[k*AW +: AW]] <= mem_data_wr[k*DW +: DW];
    end
  end

  always_comb begin
    mem_data_rd = '0;
    for (int k = 0; k < NB; k++) mem_data_rd[k*DW +: DW] = ram[mem_address[k*AW +: AW]];
  end

  // Reference model
  typedef struct { int due; int port; logic [DW-1:0] data; } rd_t;
  rd_t           m_q [$];
  logic [DW-1:0] m_mem [32];
  int            m_ptr = 0;
  int            m_cyc = 0;
  bit            m_rst_prev = 1'b1;
  logic [NB-1:0] m_mwe_pend = '1;
  logic [NP-1:0] e_gnt, e_rv;
  logic [NB-1:0] e_mwe;
  logic [DW-1:0] e_drd [NP];
  logic [NP-1:0] s_gnt, s_rv;
  logic [NB-1:0] s_mwe;
  logic [DW-1:0] s_drd [NP];

  task automatic model_cycle();
    int sel [$];
    e_rv = '0;
    if (m_rst_prev) begin
      for (int p = 0; p < NP; p++) e_drd[p] = '0;
      e_mwe = '1;
    end else begin
      e_mwe = m_mwe_pend;
    end
    while (m_q.size() > 0 && m_q[0].due <= m_cyc) begin
      if (m_q[0].due == m_cyc) begin
        e_rv[m_q[0].port]  = 1'b1;
        e_drd[m_q[0].port] = m_q[0].data;
      end
      void'(m_q.pop_front());
    end
    e_gnt = '0;
    m_mwe_pend = '1;
    if (reset) begin
      m_q.delete();
      m_ptr = 0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        int p;
        bit ok;
        p  = (m_ptr + i) % NP;
        ok = t_req[p] && (sel.size() < NB);
        foreach (sel[j])
          if (t_addr[sel[j]] == t_addr[p] && !(t_we_n[sel[j]] && t_we_n[p])) ok = 1'b0;
        if (ok) sel.push_back(p);
      end
      foreach (sel[k]) begin
        e_gnt[sel[k]] = 1'b1;
        m_mwe_pend[k] = t_we_n[sel[k]];
        if (t_we_n[sel[k]]) m_q.push_back('{m_cyc + 2, sel[k], m_mem[t_addr[sel[k]]]});
      end
      foreach (sel[k]) if (!t_we_n[sel[k]]) m_mem[t_addr[sel[k]]] = t_wd[sel[k]];
      if (sel.size() > 0) m_ptr = (sel[sel.size()-1] + 1) % NP;
    end
    m_rst_prev = reset;
    m_cyc++;
  endtask

  // Sample DUT on the falling edge, advance model, return just after next rise.
  task automatic tick();
    @(negedge clk);
    s_gnt = gnt;
    s_rv  = rd_valid;
    s_mwe = mem_we_n;
    for (int p = 0; p < NP; p++) s_drd[p] = data_rd[p*DW +: DW];
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_granted();
    for (int p = 0; p < NP; p++) if (e_gnt[p]) t_req[p] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    t_req = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ram_clr = 1'b1;
    t_req = '1;
    t_we_n = '1;
    for (int p = 0; p < NP; p++) begin t_addr[p] = AW'(p); t_wd[p] = '0; end
    @(posedge clk);
    #1;
    ram_clr = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (s_gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", s_gnt); end
      checks++; if (s_rv !== 4'b0000) begin failures++; $display("FAIL reset_rv got=%b exp=0000", s_rv); end
      checks++; if (s_mwe !== 2'b11) begin failures++; $display("FAIL reset_mem_we_n got=%b exp=11", s_mwe); end
    end
    reset = 1'b0;
    t_req = '0;
  endtask

  task automatic test_write_read();
    t_req = 4'b0001; t_we_n[0] = 1'b0; t_addr[0] = 5'd3; t_wd[0] = 32'hDEADBEEF;
    tick();
    checks++; if (s_gnt !== 4'b0001) begin failures++; $display("FAIL wr_gnt got=%b exp=0001", s_gnt); end
    drop_granted();
    t_req[0] = 1'b1; t_we_n[0] = 1'b1;
    tick();
    checks++; if (s_gnt !== 4'b0001) begin failures++; $display("FAIL rd_gnt got=%b exp=0001", s_gnt); end
    drop_granted();
    tick();
    checks++; if (s_rv !== 4'b0000) begin failures++; $display("FAIL wr_rd_early_rv got=%b exp=0000", s_rv); end
    tick();
    checks++; if (s_rv !== 4'b0001) begin failures++; $display("FAIL wr_rd_rv got=%b exp=0001", s_rv); end
    checks++; if (s_drd[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rd_data got=%h exp=deadbeef", s_drd[0]); end
  endtask

  task automatic test_parallel_reads();
    do_reset();
    t_req = '1; t_we_n = '1;
    for (int p = 0; p < NP; p++) t_addr[p] = AW'(p);
    tick();
    checks++; if (s_gnt !== 4'b0011) begin failures++; $display("FAIL par_gnt0 got=%b exp=0011", s_gnt); end
    drop_granted();
    tick();
    checks++; if (s_gnt !== 4'b1100) begin failures++; $display("FAIL par_gnt1 got=%b exp=1100", s_gnt); end
    drop_granted();
    tick();
    checks++; if (s_rv !== 4'b0011) begin failures++; $display("FAIL par_rv0 got=%b exp=0011", s_rv); end
    checks++; if (s_drd[1] !== init_word(1)) begin failures++; $display("FAIL par_data1 got=%h exp=%h", s_drd[1], init_word(1)); end
    tick();
    checks++; if (s_rv !== 4'b1100) begin failures++; $display("FAIL par_rv1 got=%b exp=1100", s_rv); end
    checks++; if (s_drd[2] !== init_word(2)) begin failures++; $display("FAIL par_data2 got=%h exp=%h", s_drd[2], init_word(2)); end
    checks++; if (s_drd[3] !== 32'hDEADBEEF) begin failures++; $display("FAIL par_data3 got=%h exp=deadbeef", s_drd[3]); end
    checks++; if (s_drd[0] !== init_word(0)) begin failures++; $display("FAIL par_hold0 got=%h exp=%h", s_drd[0], init_word(0)); end
  endtask

  task automatic test_fairness();
    int cnt [NP];
    logic [NP-1:0] exp_g;
    do_reset();
    for (int p = 0; p < NP; p++) begin cnt[p] = 0; t_addr[p] = AW'(p + 8); end
    t_req = '1; t_we_n = '1;
    for (int c = 0; c < 8; c++) begin
      tick();
      exp_g = (c % 2 == 0) ? 4'b0011 : 4'b1100;
      checks++; if (s_gnt !== exp_g) begin failures++; $display("FAIL fair_gnt c=%0d got=%b exp=%b", c, s_gnt, exp_g); end
      checks++; if (s_rv !== e_rv) begin failures++; $display("FAIL fair_rv c=%0d got=%b exp=%b", c, s_rv, e_rv); end
      for (int p = 0; p < NP; p++) if (s_gnt[p] === 1'b1) cnt[p]++;
    end
    t_req = '0;
    for (int p = 0; p < NP; p++) begin
      checks++; if (cnt[p] != 4) begin failures++; $display("FAIL fair_count port=%0d got=%0d exp=4", p, cnt[p]); end
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (s_rv !== e_rv) begin failures++; $display("FAIL fair_drain_rv got=%b exp=%b", s_rv, e_rv); end
      checks++; if (s_drd[c+2] !== init_word(c + 10)) begin failures++; $display("FAIL fair_drain_data got=%h exp=%h", s_drd[c+2], init_word(c + 10)); end
    end
  endtask

  task automatic test_back_to_back();
    t_req = 4'b0010; t_we_n = '1;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin t_req[1] = 1'b1; t_addr[1] = AW'(c); end
      tick();
      checks++; if (s_gnt !== e_gnt) begin failures++; $display("FAIL b2b_gnt c=%0d got=%b exp=%b", c, s_gnt, e_gnt); end
      if (c >= 2) begin
        checks++; if (s_rv !== 4'b0010) begin failures++; $display("FAIL b2b_rv c=%0d got=%b exp=0010", c, s_rv); end
        checks++; if (s_drd[1] !== init_word(c - 2)) begin failures++; $display("FAIL b2b_data c=%0d got=%h exp=%h", c, s_drd[1], init_word(c - 2)); end
      end
      drop_granted();
    end
  endtask

  task automatic test_conflict();
    do_reset();
    t_req = 4'b0011;
    t_we_n[0] = 1'b0; t_addr[0] = 5'd5; t_wd[0] = 32'h5;
    t_we_n[1] = 1'b1; t_addr[1] = 5'd5;
    tick();
    checks++; if (s_gnt !== 4'b0001) begin failures++; $display("FAIL conf_gnt0 got=%b exp=0001", s_gnt); end
    drop_granted();
    tick();
    checks++; if (s_gnt !== 4'b0010) begin failures++; $display("FAIL conf_gnt1 got=%b exp=0010", s_gnt); end
    drop_granted();
    tick();
    tick();
    checks++; if (s_rv !== 4'b0010) begin failures++; $display("FAIL conf_rv got=%b exp=0010", s_rv); end
    checks++; if (s_drd[1] !== 32'h5) begin failures++; $display("FAIL conf_data got=%h exp=00000005", s_drd[1]); end
  endtask

  task automatic test_reset_midop();
    t_req = 4'b0100; t_we_n = '1; t_addr[2] = 5'd7;
    tick();
    checks++; if (s_gnt !== 4'b0100) begin failures++; $display("FAIL mid_gnt got=%b exp=0100", s_gnt); end
    reset = 1'b1; t_req = '0;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (s_rv !== 4'b0000) begin failures++; $display("FAIL mid_rv c=%0d got=%b exp=0000", c, s_rv); end
    end
    t_req = '1;
    for (int p = 0; p < NP; p++) t_addr[p] = AW'(p + 16);
    tick();
    checks++; if (s_gnt !== 4'b0011) begin failures++; $display("FAIL mid_restart_gnt got=%b exp=0011", s_gnt); end
    drop_granted();
    tick();
    drop_granted();
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (s_rv !== e_rv) begin failures++; $display("FAIL mid_drain_rv got=%b exp=%b", s_rv, e_rv); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      for (int p = 0; p < NP; p++) begin
        if (!t_req[p] && $urandom_range(0, 2) != 0) begin
          t_req[p]  = 1'b1;
          t_we_n[p] = ($urandom_range(0, 2) != 0);
          t_addr[p] = AW'($urandom_range(0, 7));
          t_wd[p]   = $urandom;
        end
      end
      tick();
      checks++; if (s_gnt !== e_gnt) begin failures++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, s_gnt, e_gnt); end
      checks++; if (s_rv !== e_rv) begin failures++; $display("FAIL rnd_rv c=%0d got=%b exp=%b", c, s_rv, e_rv); end
      checks++; if (s_mwe !== e_mwe) begin failures++; $display("FAIL rnd_mem_we_n c=%0d got=%b exp=%b", c, s_mwe, e_mwe); end
      for (int p = 0; p < NP; p++) begin
        checks++; if (s_drd[p] !== e_drd[p]) begin failures++; $display("FAIL rnd_data c=%0d port=%0d got=%h exp=%h", c, p, s_drd[p], e_drd[p]); end
      end
      drop_granted();
    end
    reset = 1'b0;
    t_req = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (s_rv !== e_rv) begin failures++; $display("FAIL rnd_drain_rv got=%b exp=%b", s_rv, e_rv); end
      for (int p = 0; p < NP; p++) begin
        checks++; if (s_drd[p] !== e_drd[p]) begin failures++; $display("FAIL rnd_drain_data port=%0d got=%h exp=%h", p, s_drd[p], e_drd[p]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = init_word(i);
    for (int p = 0; p < NP; p++) e_drd[p] = '0;
    test_reset();
    test_write_read();
    test_parallel_reads();
    test_fairness();
    test_back_to_back();
    test_conflict();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
